// File: rtl/hdmi_pkg.sv
// Shared HDMI control package.
// Holds the I2C direction constants used by the initiator and the target,
// and the state encoding of the ADV7511-style I2C register target.
package hdmi_pkg;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchronizer with edge detection for one I2C bus line.
// Ports:
//   clk_i   - system clock
//   rst_ni  - synchronous active-low reset (chain resets to 1 = idle bus)
//   d_i     - asynchronous bus line
//   level_o - synchronized line level
//   rise_o  - one-cycle pulse on synchronized 0->1
//   fall_o  - one-cycle pulse on synchronized 1->0
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adv7511_i2c_target.sv
// I2C register target with a 256 x 8 register file, modelled on the
// ADV7511 main map access scheme: address byte, pointer byte, then data
// bytes with pointer auto-increment (write) or sequential read.
// Ports:
//   clk_i, rst_ni          - system clock, synchronous active-low reset
//   scl_i, sda_i           - bus lines as seen on the wire
//   sda_oe_o               - 1 pulls SDA low (open drain)
//   wr_valid_o/addr/data   - one-cycle notification of each bus register write
//   rd_addr_i, rd_data_o   - combinational side-port read of the register file
//   busy_o                 - target is addressed and engaged in a transfer
//
// state        | meaning
// IDLE         | bus free or target not engaged
// ADDR         | shifting in address + R/W
// ADDR_ACK     | acknowledging our address
// PTR          | shifting in register pointer
// PTR_ACK      | acknowledging pointer
// WDATA        | shifting in write data
// WDATA_ACK    | acknowledging write data
// RDATA        | shifting out read data
// RDATA_ACK    | sampling initiator ACK/NACK
// IGNORE       | not addressed / read ended; wait for START or STOP
module adv7511_i2c_target
    import hdmi_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    input  logic [7:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       busy_o
);

    logic       scl, scl_rise, scl_fall;
    logic       sda, sda_rise, sda_fall;
    i2c_state_e state, state_next;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       rw;
    logic       ack_drv;   // target ACK: set at first SCL fall, cleared at the second
    logic       mack;      // initiator ACK seen during RDATA_ACK
    logic       busy;
    logic [7:0] regs [256];

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (scl_i),
        .level_o (scl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (sda_i),
        .level_o (sda),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic       start_det, stop_det, bus_evt, byte_done, addr_match, reg_we;
    logic [7:0] rx_byte;

    assign start_det  = sda_fall & scl;
    assign stop_det   = sda_rise & scl;
    assign bus_evt    = start_det | stop_det;
    assign byte_done  = scl_rise && (bit_cnt == 4'd7);
    assign rx_byte    = {shift[6:0], sda};
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    assign reg_we     = !bus_evt && (state == ST_WDATA) && byte_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:      if (byte_done) state_next = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (scl_fall && ack_drv)
                                  state_next = (rw == I2C_READ) ? ST_RDATA : ST_PTR;
                ST_PTR:       if (byte_done) state_next = ST_PTR_ACK;
                ST_PTR_ACK:   if (scl_fall && ack_drv) state_next = ST_WDATA;
                ST_WDATA:     if (byte_done) state_next = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall && ack_drv) state_next = ST_WDATA;
                ST_RDATA:     if (scl_fall && bit_cnt == 4'd8) state_next = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda) state_next = ST_IGNORE;
                    else if (scl_fall && mack) state_next = ST_RDATA;
                end
                default:      state_next = state;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_o = ack_drv;
            ST_RDATA:                              sda_oe_o = ~shift[7];
            default:                               sda_oe_o = 1'b0;
        endcase
        busy_o = busy;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            rw         <= I2C_WRITE;
            ack_drv    <= 1'b0;
            mack       <= 1'b0;
            busy       <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            wr_valid_o <= 1'b0;
            if (bus_evt) begin
                // Any partial byte is dropped; busy survives a repeated START.
                bit_cnt <= '0;
                ack_drv <= 1'b0;
                mack    <= 1'b0;
                if (stop_det) busy <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
                        if (byte_done) begin
                            if (state == ST_ADDR) begin
                                rw   <= rx_byte[0];
                                busy <= addr_match;
                            end else if (state == ST_PTR) begin
                                ptr <= rx_byte;
                            end else begin
                                wr_valid_o <= 1'b1;
                                wr_addr_o  <= ptr;
                                wr_data_o  <= rx_byte;
                                ptr        <= ptr + 8'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        ack_drv <= ~ack_drv;
                        if (ack_drv && state == ST_ADDR_ACK && rw == I2C_READ)
                            shift <= regs[ptr];
                    end
                    ST_RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                ptr     <= ptr + 8'd1;
                            end else begin
                                shift <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda) mack <= 1'b1;
                            else      busy <= 1'b0;
                        end
                        if (scl_fall && mack) begin
                            mack  <= 1'b0;
                            shift <= regs[ptr];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
        end else if (reg_we) begin
            regs[ptr] <= rx_byte;
        end
    end

    // Registered write: a same-cycle side read still returns the old value.
    assign rd_data_o = regs[rd_addr_i];

endmodule

// File: tb/tb_adv7511_i2c_target.sv
// Bench for adv7511_i2c_target: bit-banged I2C initiator, register shadow
// model, and write/read scoreboards.
module tb_adv7511_i2c_target;
    import hdmi_pkg::*;

    localparam int Q = 8;
    localparam logic [7:0] AW = {7'h39, I2C_WRITE};
    localparam logic [7:0] AR = {7'h39, I2C_READ};

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] old;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe_o, wr_valid_o, busy_o;
    logic [7:0] wr_addr_o, wr_data_o, rd_data_o;
    logic [7:0] rd_addr = 8'h00;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mem [256];
    wr_t        exp_wr [$];
    logic [7:0] rd_exp [$];
    logic [7:0] tx_q [$];
    wr_t        e;
    logic [7:0] rd_prev = 8'h00;
    logic       oe_prev = 1'b0, rst_prev = 1'b0, oe_seen = 1'b0;

    always #5 clk = ~clk;
    assign sda_bus = sda_drv & ~sda_oe_o;

    adv7511_i2c_target #(.DEV_ADDR(7'h39), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_o),
        .busy_o     (busy_o)
    );

    // Write scoreboard, same-cycle read-port check, SDA-only-while-SCL-low check.
    always @(negedge clk) begin
        if (rst_n && wr_valid_o) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected", wr_addr_o, wr_data_o);
            end else begin
                e = exp_wr.pop_front();
                if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
                    n_fail++;
                    $display("FAIL write_event: got %h/%h expected %h/%h", wr_addr_o, wr_data_o, e.addr, e.data);
                end
                if (rd_addr == wr_addr_o) begin
                    n_checks++;
                    if (rd_prev !== e.old || rd_data_o !== e.data) begin
                        n_fail++;
                        $display("FAIL rd_same_cycle: got old %h new %h expected old %h new %h", rd_prev, rd_data_o, e.old, e.data);
                    end
                end
            end
        end
        if (rst_n && rst_prev && sda_oe_o !== oe_prev) begin
            n_checks++;
            if (scl !== 1'b0) begin
                n_fail++;
                $display("FAIL sda_change_scl_high: got scl %b expected 0", scl);
            end
        end
        if (sda_oe_o === 1'b1) oe_seen = 1'b1;
        rd_prev  = rd_data_o;
        oe_prev  = sda_oe_o;
        rst_prev = rst_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; hold(Q);
        scl = 1'b1;     hold(Q);
        sda_drv = 1'b0; hold(Q);
        scl = 1'b0;     hold(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; hold(Q);
        scl = 1'b1;     hold(Q);
        sda_drv = 1'b1; hold(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; hold(Q);
        scl = 1'b1;  hold(2 * Q);
        scl = 1'b0;  hold(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; hold(Q);
        scl = 1'b1;     hold(Q);
        ack = ~sda_bus; hold(Q);
        scl = 1'b0;     hold(Q);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic give_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = 1'b1; hold(Q);
            scl = 1'b1;     hold(Q);
            b[i] = sda_bus; hold(Q);
            scl = 1'b0;     hold(Q);
        end
        send_bit(give_ack ? 1'b0 : 1'b1);
        sda_drv = 1'b1;
    endtask

    task automatic send_bytes(output logic [7:0] acks);
        logic a;
        acks = '0;
        for (int i = 0; i < tx_q.size(); i++) begin
            write_byte(tx_q[i], a);
            acks[i] = a;
        end
    endtask

    task automatic push_wr(input logic [7:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        w.old  = mem[addr];
        exp_wr.push_back(w);
        mem[addr] = data;
    endtask

    task automatic test_reset();
        logic [7:0] probe [3];
        probe = '{8'h00, 8'h41, 8'hFF};
        rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        hold(4);
        n_checks++;
        if ({sda_oe_o, wr_valid_o, busy_o, wr_addr_o, wr_data_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {sda_oe_o, wr_valid_o, busy_o, wr_addr_o, wr_data_o});
        end
        rst_n = 1'b1; hold(4);
        for (int i = 0; i < 3; i++) begin
            rd_addr = probe[i]; hold(1);
            n_checks++;
            if (rd_data_o !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg_%h: got %h expected 00", probe[i], rd_data_o);
            end
        end
    endtask

    task automatic test_single_write();
        logic [7:0] acks;
        tx_q = '{AW, 8'h41, 8'h10};
        push_wr(8'h41, 8'h10);
        i2c_start();
        send_bytes(acks);
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy_o); end
        i2c_stop(); hold(4);
        n_checks++;
        if (acks[2:0] !== 3'b111) begin n_fail++; $display("FAIL single_acks: got %b expected 111", acks[2:0]); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_stop: got %b expected 0", busy_o); end
        n_checks++;
        if (exp_wr.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", exp_wr.size()); end
        rd_addr = 8'h41; hold(1);
        n_checks++;
        if (rd_data_o !== mem[8'h41]) begin n_fail++; $display("FAIL single_reg41: got %h expected %h", rd_data_o, mem[8'h41]); end
    endtask

    task automatic test_wrap();
        logic [7:0] acks;
        tx_q = '{AW, 8'hFF, 8'hAA, 8'hBB};
        push_wr(8'hFF, 8'hAA);
        push_wr(8'h00, 8'hBB);
        i2c_start(); send_bytes(acks); i2c_stop(); hold(4);
        n_checks++;
        if (acks[3:0] !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks: got %b expected 1111", acks[3:0]); end
        n_checks++;
        if (exp_wr.size() != 0) begin n_fail++; $display("FAIL wrap_pending: got %0d expected 0", exp_wr.size()); end
        rd_addr = 8'hFF; hold(1);
        n_checks++;
        if (rd_data_o !== mem[8'hFF]) begin n_fail++; $display("FAIL wrap_regFF: got %h expected %h", rd_data_o, mem[8'hFF]); end
        rd_addr = 8'h00; hold(1);
        n_checks++;
        if (rd_data_o !== mem[8'h00]) begin n_fail++; $display("FAIL wrap_reg00: got %h expected %h", rd_data_o, mem[8'h00]); end
    endtask

    task automatic test_read();
        logic [7:0] acks, b, x;
        tx_q = '{AW, 8'h42, 8'h5C};
        push_wr(8'h42, 8'h5C);
        i2c_start(); send_bytes(acks); i2c_stop();
        n_checks++;
        if (acks[2:0] !== 3'b111) begin n_fail++; $display("FAIL read_prep_acks: got %b expected 111", acks[2:0]); end
        tx_q = '{AW, 8'h41};
        i2c_start(); send_bytes(acks);
        n_checks++;
        if (acks[1:0] !== 2'b11) begin n_fail++; $display("FAIL read_ptr_acks: got %b expected 11", acks[1:0]); end
        tx_q = '{AR};
        i2c_start(); send_bytes(acks);
        n_checks++;
        if (acks[0] !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL read_addr_ack: got ack %b busy %b expected 1 1", acks[0], busy_o);
        end
        rd_exp.push_back(mem[8'h41]);
        rd_exp.push_back(mem[8'h42]);
        for (int i = 0; i < 2; i++) begin
            read_byte(b, i == 0);
            x = rd_exp.pop_front();
            n_checks++;
            if (b !== x) begin n_fail++; $display("FAIL read_byte%0d: got %h expected %h", i, b, x); end
        end
        hold(4);
        n_checks++;
        if (sda_oe_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL read_nack_release: got oe %b busy %b expected 0 0", sda_oe_o, busy_o);
        end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        logic [7:0] acks;
        oe_seen = 1'b0;
        tx_q = '{8'h74, 8'h55};
        i2c_start(); send_bytes(acks);
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wrong_busy: got %b expected 0", busy_o); end
        i2c_stop(); hold(4);
        n_checks++;
        if (acks[1:0] !== 2'b00) begin n_fail++; $display("FAIL wrong_acks: got %b expected 00", acks[1:0]); end
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL wrong_sda_driven: got %b expected 0", oe_seen); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] acks;
        logic [7:0] probe [3];
        logic [7:0] d;
        probe = '{8'h41, 8'h60, 8'hFF};
        d = 8'h3C;
        tx_q = '{AW, 8'h60};
        i2c_start(); send_bytes(acks);
        n_checks++;
        if (acks[1:0] !== 2'b11) begin n_fail++; $display("FAIL rstack_acks: got %b expected 11", acks[1:0]); end
        push_wr(8'h60, d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_drv = 1'b1; hold(Q);
        n_checks++;
        if (sda_oe_o !== 1'b1) begin n_fail++; $display("FAIL rstack_driving: got %b expected 1", sda_oe_o); end
        rst_n = 1'b0; hold(1);
        n_checks++;
        if (sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rstack_release: got %b expected 0", sda_oe_o); end
        hold(3); rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        i2c_stop(); hold(4);
        n_checks++;
        if (exp_wr.size() != 0) begin n_fail++; $display("FAIL rstack_pending: got %0d expected 0", exp_wr.size()); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = probe[i]; hold(1);
            n_checks++;
            if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL rstack_reg_%h: got %h expected 00", probe[i], rd_data_o); end
        end
        tx_q = '{AW, 8'h20, 8'h66};
        push_wr(8'h20, 8'h66);
        i2c_start(); send_bytes(acks); i2c_stop(); hold(4);
        n_checks++;
        if (acks[2:0] !== 3'b111) begin n_fail++; $display("FAIL rstack_after_acks: got %b expected 111", acks[2:0]); end
        rd_addr = 8'h20; hold(1);
        n_checks++;
        if (rd_data_o !== mem[8'h20]) begin n_fail++; $display("FAIL rstack_reg20: got %h expected %h", rd_data_o, mem[8'h20]); end
    endtask

    task automatic test_start_mid_byte();
        logic [7:0] acks;
        tx_q = '{AW, 8'h30};
        i2c_start(); send_bytes(acks);
        n_checks++;
        if (acks[1:0] !== 2'b11) begin n_fail++; $display("FAIL midbyte_ptr_acks: got %b expected 11", acks[1:0]); end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        rd_addr = 8'h30; hold(1);
        n_checks++;
        if (rd_data_o !== mem[8'h30]) begin n_fail++; $display("FAIL midbyte_no_write: got %h expected %h", rd_data_o, mem[8'h30]); end
        tx_q = '{AW, 8'h30, 8'h99};
        push_wr(8'h30, 8'h99);
        send_bytes(acks); i2c_stop(); hold(4);
        n_checks++;
        if (acks[2:0] !== 3'b111) begin n_fail++; $display("FAIL midbyte_readdr_acks: got %b expected 111", acks[2:0]); end
        n_checks++;
        if (rd_data_o !== mem[8'h30]) begin n_fail++; $display("FAIL midbyte_reg30: got %h expected %h", rd_data_o, mem[8'h30]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] acks, b, x;
        tx_q = '{AW, 8'h50, 8'h11, 8'h22};
        push_wr(8'h50, 8'h11); push_wr(8'h51, 8'h22);
        i2c_start(); send_bytes(acks); i2c_stop();
        n_checks++;
        if (acks[3:0] !== 4'b1111) begin n_fail++; $display("FAIL b2b_first_acks: got %b expected 1111", acks[3:0]); end
        rd_addr = 8'h51;
        tx_q = '{AW, 8'h51, 8'h77, 8'h88};
        push_wr(8'h51, 8'h77); push_wr(8'h52, 8'h88);
        i2c_start(); send_bytes(acks); i2c_stop();
        n_checks++;
        if (acks[3:0] !== 4'b1111) begin n_fail++; $display("FAIL b2b_second_acks: got %b expected 1111", acks[3:0]); end
        tx_q = '{AW, 8'h50};
        i2c_start(); send_bytes(acks);
        tx_q = '{AR};
        i2c_start(); send_bytes(acks);
        for (int i = 0; i < 3; i++) rd_exp.push_back(mem[8'h50 + i]);
        for (int i = 0; i < 3; i++) begin
            read_byte(b, i < 2);
            x = rd_exp.pop_front();
            n_checks++;
            if (b !== x) begin n_fail++; $display("FAIL b2b_read%0d: got %h expected %h", i, b, x); end
        end
        i2c_stop(); hold(4);
        n_checks++;
        if (exp_wr.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d expected 0", exp_wr.size()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrap();
        test_read();
        test_wrong_addr();
        test_start_mid_byte();
        test_back_to_back();
        test_reset_mid_ack();
        hold(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adv7511_i2c_target.md
ADV7511_I2C_TARGET -- requirements
Module: adv7511_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h39, 7-bit target address that is responded to.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth for scl_i and sda_i; minimum 2.
REQ-003 clk_i  input  1  system clock; one clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 scl_i  input  1  I2C clock from bus (initiator only; no clock stretching).
REQ-006 sda_i  input  1  I2C data as seen on bus.
REQ-007 sda_oe_o  output  1  1 = pull SDA low (open drain); 0 = release.
REQ-008 wr_valid_o  output  1  one-cycle pulse per register byte written from the bus.
REQ-009 wr_addr_o  output  8  register index of that write.
REQ-010 wr_data_o  output  8  data of that write.
REQ-011 rd_addr_i  input  8  side-port register index.
REQ-012 rd_data_o  output  8  combinational read of register rd_addr_i.
REQ-013 busy_o  output  1  high from addressed START (address match) until STOP or NACK exit.

Function
REQ-014 scl_i/sda_i SHALL pass SYNC_STAGES flops plus one edge-detect flop; all decisions use synchronized values.
REQ-015 START = synchronized SDA fall while SCL high; STOP = SDA rise while SCL high; both SHALL be recognized in every state.
REQ-016 START (including repeated START) SHALL enter ADDR with bit counter 0; STOP SHALL enter IDLE and release SDA.
REQ-017 Bits SHALL be sampled on synchronized SCL rise; sda_oe_o SHALL change only on synchronized SCL fall.
REQ-018 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-019 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go ADDR_ACK, else IGNORE (SDA released until next START/STOP).
REQ-020 ACK states: assert sda_oe_o from SCL fall after bit 8 until SCL fall after bit 9.
REQ-021 ADDR_ACK with R/W=0 -> PTR; with R/W=1 -> RDATA, shift register loaded from reg[ptr] at SCL fall ending the ACK.
REQ-022 PTR: 8 bits load pointer; -> PTR_ACK -> WDATA.
REQ-023 WDATA: on 8th bit rise, reg[ptr]<=byte, wr_valid_o pulses with wr_addr_o=ptr, wr_data_o=byte, ptr increments; -> WDATA_ACK -> WDATA.
REQ-024 RDATA: MSB first, sda_oe_o = ~bit on each SCL fall; after 8 bits release SDA and enter RDATA_ACK; ptr increments after each byte.
REQ-025 RDATA_ACK: initiator ACK (SDA low at SCL rise) -> reload from reg[ptr], RDATA; NACK -> IGNORE.
REQ-026 Pointer SHALL wrap 8'hFF -> 8'h00 on both write and read auto-increment.
REQ-027 Pointer SHALL persist across transactions so a write of PTR only followed by a repeated-START read reads from that pointer.
REQ-028 Simultaneous bus write and rd_addr_i to same register: rd_data_o SHALL show the old value that cycle, new value the next.
REQ-029 START mid-byte SHALL abandon the partial byte with no register write and no wr_valid_o.

Reset
REQ-030 On rst_ni low at clk_i rise: state IDLE, sda_oe_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, ptr=0, all 256 registers 8'h00, synchronizers set to 1 (bus idle).
REQ-031 Reset mid-transaction SHALL release SDA within the same cycle it is sampled; target re-engages only on the next START.

Structure
REQ-032 State enum and I2C_READ/I2C_WRITE constants SHALL live in shared package hdmi_pkg used by the existing I2C initiator.
REQ-033 One sub-module i2c_sync_edge (synchronizer plus rise/fall detect), instanced for SCL and SDA.

Verification
REQ-034 Write 0x72,0x41,0x10 (addr 0x39 W, ptr 0x41, data) -> ACK on all three bytes, wr_valid_o pulse with addr 0x41 data 0x10, rd_data_o[0x41]=0x10.
REQ-035 Write 0x72,0xFF,0xAA,0xBB -> regs 0xFF=0xAA, 0x00=0xBB (wrap).
REQ-036 Write 0x72,0x41, repeated START, 0x73, read two bytes ACK then NACK -> bus bytes 0x10 then reg 0x42, SDA released after NACK.
REQ-037 Address 0x74 (0x3A W) then data 0x55 -> no ACK, sda_oe_o stays 0, no wr_valid_o, busy_o stays 0.
REQ-038 rst_ni low during ACK of data byte -> sda_oe_o=0 next cycle, all regs 0x00, next correct write accepted.
REQ-039 START after 4 data bits of a write byte -> no register change, new ADDR phase ACKed for 0x72.
